west_skew_feeder: RTL and testbench

- Upstream feeder for the west edge of the systolic PE array.
- Accepts one activation vector per handshake, one element per array row. Delays row r by r cycles so each row's activation reaches its first PE in the correct diagonal wavefront.
- Inserts zero bubbles when no data is accepted. Drains the skew pipeline after the last vector of a tile and signals tile completion to the array controller.

---
 rtl/west_skew_feeder_if.sv | 27 ++
 rtl/west_skew_feeder.sv | 78 +++++++
 tb/tb_west_skew_feeder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/west_skew_feeder_if.sv
// west_skew_feeder_if: vector handshake and skewed west-edge bus; stats ports exist only with WEST_FEEDER_STATS_EN
interface west_skew_feeder_if #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic [ROWS*DATA_W-1:0] in_data;
  logic [ROWS*DATA_W-1:0] out_data;
  logic [ROWS-1:0]        out_valid;
  logic                   busy;
  logic                   tile_done;
`ifdef WEST_FEEDER_STATS_EN
  logic [31:0]            vec_cnt;
  logic [31:0]            zero_cnt;
  modport master (output in_valid, in_last, in_data,
                  input  in_ready, out_data, out_valid, busy, tile_done, vec_cnt, zero_cnt);
  modport slave  (input  in_valid, in_last, in_data,
                  output in_ready, out_data, out_valid, busy, tile_done, vec_cnt, zero_cnt);
`else
  modport master (output in_valid, in_last, in_data,
                  input  in_ready, out_data, out_valid, busy, tile_done);
  modport slave  (input  in_valid, in_last, in_data,
                  output in_ready, out_data, out_valid, busy, tile_done);
`endif
endinterface

// File: rtl/west_skew_feeder.sv
// west_skew_feeder: skews activation vectors onto the array west edge, drains tiles; optional WEST_FEEDER_STATS_EN counters
module west_skew_feeder #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  west_skew_feeder_if.slave bus
);
  localparam int CW = $clog2(ROWS + 1);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [ROWS-1:0] last_sr;
  logic            acc;
  assign acc           = bus.in_valid && bus.in_ready;
  assign bus.in_ready  = state != FLUSH;
  assign bus.busy      = state != IDLE;
  assign bus.tile_done = last_sr[ROWS-1];
  // tile FSM: stream until the last vector, then hold off input while the skew drains
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, STREAM:
          if (acc && bus.in_last) begin
            state <= (ROWS == 1) ? IDLE : FLUSH;
            cnt   <= CW'(ROWS - 1);
          end else if (acc) state <= STREAM;
        FLUSH: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // last-flag delay line matching the deepest lane, so tile_done lines up with its final element
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_sr <= '0;
    else last_sr <= (last_sr << 1) | ROWS'(acc && bus.in_last);
  for (genvar g = 0; g < ROWS; g++) begin : lane
    logic [DATA_W-1:0] d [g+1];
    logic [g:0]        v;
    // lane g: free-running (g+1)-stage chain; non-accept cycles inject a zero bubble
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        for (int i = 0; i <= g; i++) d[i] <= '0;
        v <= '0;
      end else begin
        d[0] <= acc ? bus.in_data[g*DATA_W +: DATA_W] : '0;
        for (int i = 1; i <= g; i++) d[i] <= d[i-1];
        v <= (v << 1) | (g+1)'(acc);
      end
    assign bus.out_data[g*DATA_W +: DATA_W] = d[g];
    assign bus.out_valid[g]                 = v[g];
  end
`ifdef WEST_FEEDER_STATS_EN
  logic [CW-1:0] zeros;
  logic [32:0]   zsum;
  // zero lanes in the offered vector
  always_comb begin
    zeros = '0;
    for (int i = 0; i < ROWS; i++) zeros += CW'(bus.in_data[i*DATA_W +: DATA_W] == '0);
  end
  assign zsum = {1'b0, bus.zero_cnt} + 33'(zeros);
  // saturating sparsity counters, cleared only by reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.vec_cnt  <= '0;
      bus.zero_cnt <= '0;
    end else if (acc) begin
      bus.vec_cnt  <= &bus.vec_cnt ? bus.vec_cnt : bus.vec_cnt + 1'b1;
      bus.zero_cnt <= zsum[32] ? '1 : zsum[31:0];
    end
`endif
endmodule

// File: tb/tb_west_skew_feeder.sv
// tb_west_skew_feeder: directed plus random stimulus against an edge-indexed history model
module tb_west_skew_feeder;
  localparam int ROWS   = 4;
  localparam int DATA_W = 32;
  localparam int W      = ROWS * DATA_W;
  localparam int MAXC   = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  west_skew_feeder_if #(.ROWS(ROWS), .DATA_W(DATA_W)) bus ();
  west_skew_feeder #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic   open_tile;
  logic   av [MAXC];
  logic   al [MAXC];
  logic [W-1:0] ad [MAXC];
  longint vc, zc;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // a vector whose last flag was accepted at edge e blocks input during cycles e+1 .. e+ROWS-1
  function automatic logic flushing(input int n);
    for (int e = n - ROWS + 1; e < n; e++)
      if (e >= 0 && av[e] && al[e]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {DATA_W'(l3), DATA_W'(l2), DATA_W'(l1), DATA_W'(l0)};
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] d;
    for (int r = 0; r < ROWS; r++)
      d[r*DATA_W +: DATA_W] = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
    return d;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      av[i] = 1'b0;
      al[i] = 1'b0;
      ad[i] = '0;
    end
    cyc = 0;
    open_tile = 1'b0;
    vc = 0;
    zc = 0;
  endtask

  // lane r in cycle n shows whatever was accepted at edge n-1-r, else zero
  task automatic check_all();
    logic [W-1:0]    ed;
    logic [ROWS-1:0] ev;
    int e;
    ed = '0;
    ev = '0;
    for (int r = 0; r < ROWS; r++) begin
      e = cyc - 1 - r;
      if (e >= 0 && av[e]) begin
        ed[r*DATA_W +: DATA_W] = ad[e][r*DATA_W +: DATA_W];
        ev[r] = 1'b1;
      end
    end
    e = cyc - ROWS;
    chk("out_data", bus.out_data, ed);
    chk("out_valid", W'(bus.out_valid), W'(ev));
    chk("in_ready", W'(bus.in_ready), W'(!flushing(cyc)));
    chk("busy", W'(bus.busy), W'(open_tile || flushing(cyc)));
    chk("tile_done", W'(bus.tile_done), W'(e >= 0 && av[e] && al[e]));
`ifdef WEST_FEEDER_STATS_EN
    chk("vec_cnt", W'(bus.vec_cnt), W'(vc));
    chk("zero_cnt", W'(bus.zero_cnt), W'(zc));
`endif
  endtask

  // drive at the falling edge, record the model's view of the handshake, check after the rising edge
  task automatic step(input logic v, input logic l, input logic [W-1:0] d);
    logic a;
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_data  = d;
    a = v && !flushing(cyc);
    av[cyc] = a;
    al[cyc] = l;
    ad[cyc] = d;
    if (a) begin
      open_tile = !l;
      vc++;
      for (int r = 0; r < ROWS; r++) if (d[r*DATA_W +: DATA_W] == '0) zc++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom_range(0, 1)), rnd());
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    clear_model();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    do_reset();
`ifdef WEST_FEEDER_STATS_EN
    step(1'b1, 1'b0, pack(0, 5, 0, 0));
    step(1'b1, 1'b1, pack(7, 0, 1, 2));
    chk("vec_cnt_plan", W'(bus.vec_cnt), W'(2));
    chk("zero_cnt_plan", W'(bus.zero_cnt), W'(4));
    idle(6);
`endif
    step(1'b1, 1'b1, pack(1, 2, 3, 4));
    idle(6);
    step(1'b1, 1'b0, pack(11, 12, 13, 14));
    step(1'b1, 1'b0, pack(21, 22, 23, 24));
    step(1'b1, 1'b1, pack(31, 32, 33, 34));
    idle(6);
    step(1'b1, 1'b0, pack(-1, -2, -3, -4));
    step(1'b0, 1'b0, pack(9, 9, 9, 9));
    step(1'b0, 1'b1, pack(8, 8, 8, 8));
    step(1'b1, 1'b0, pack(41, 42, 43, 44));
    step(1'b1, 1'b1, pack(51, 52, 53, 54));
    idle(6);
    step(1'b1, 1'b1, pack(61, 62, 63, 64));
    repeat (4) step(1'b1, 1'b1, pack(71, 72, 73, 74));
    step(1'b1, 1'b1, pack(81, 82, 83, 84));
    idle(6);
    step(1'b1, 1'b1, pack(91, 92, 93, 94));
    step(1'b0, 1'b0, '0);
    do_reset();
    idle(6);
    step(1'b1, 1'b1, pack(1, 2, 3, 4));
    idle(6);
    repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, rnd());
    idle(8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
